// File: rtl/ifetch_queue_if.sv
// ifetch_queue_if: handshake/bus bundle for the instruction fetch queue.
//   imem_req/imem_addr/imem_rdata : synchronous instruction ROM port (1-cycle read latency)
//   redirect_valid/redirect_pc    : PC change request from the core
//   out_valid/out_ready/out_pc/out_instr : {pc, instr} hand-off to the core
// Modports:
//   master : the fetch queue itself
//   slave  : the environment (ROM + core)
interface ifetch_queue_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;

  modport master (
    output imem_req, imem_addr, out_valid, out_pc, out_instr,
    input  imem_rdata, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_pc, out_instr,
    output imem_rdata, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction fetch stage ahead of the single-cycle core.
//   Issues word-aligned reads to a 1-cycle-latency ROM, buffers returned
//   words with their PC in a DEPTH-entry FIFO and hands {pc, instr} pairs to
//   the core over valid/ready. Core redirects flush the FIFO and retarget
//   fetch.
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous active-high reset
//   bus    : ifetch_queue_if.master (ROM port, redirect, output handshake)
//   stall_cnt / flush_cnt : statistics, present only with IFETCH_STATS_EN
// Parameters:
//   DEPTH    : FIFO entries, power of 2, >= 2
//   RESET_PC : first fetch address after reset
// Build option:
//   IFETCH_STATS_EN : adds saturating stall_cnt (cycles with out_valid=0)
//                     and flush_cnt (redirect cycles) outputs.
module ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic            clk,
  input  logic            reset,
  ifetch_queue_if.master  bus
`ifdef IFETCH_STATS_EN
  ,
  output logic [31:0]     stall_cnt,
  output logic [15:0]     flush_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic [31:0]   fetch_pc;
  logic [31:0]   pc_q;
  logic          inflight;
  logic          kill;

  logic          req, push, pop, out_valid;
  logic [AW+1:0] used;

  // An outstanding read holds a credit, so a returning word always has room.
  always_comb begin
    used      = {1'b0, count} + {{(AW+1){1'b0}}, inflight};
    req       = !reset && !bus.redirect_valid && (used < (AW+2)'(DEPTH));
    out_valid = (count != '0);
    // Redirect flushes everything, so a same-cycle push or pop is moot.
    push      = inflight && !kill && !bus.redirect_valid;
    pop       = out_valid && bus.out_ready && !bus.redirect_valid;
  end

  assign bus.imem_req  = req;
  assign bus.imem_addr = fetch_pc;
  assign bus.out_valid = out_valid;
  assign bus.out_pc    = mem[rd_ptr].pc;
  assign bus.out_instr = mem[rd_ptr].instr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      pc_q     <= '0;
      inflight <= 1'b0;
      kill     <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      inflight <= req;
      pc_q     <= fetch_pc;
      kill     <= bus.redirect_valid && inflight;
      if (bus.redirect_valid) begin
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
      end else begin
        if (req) fetch_pc <= fetch_pc + 32'd4;
        if (push) begin
          mem[wr_ptr] <= '{pc: pc_q, instr: bus.imem_rdata};
          wr_ptr      <= wr_ptr + 1'b1;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

`ifdef IFETCH_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!out_valid && stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 32'd1;
      if (bus.redirect_valid && flush_cnt != 16'hFFFF) flush_cnt <= flush_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
module tb_ifetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ifetch_queue_if bus();

`ifdef IFETCH_STATS_EN
  logic [31:0] stall_cnt;
  logic [15:0] flush_cnt;
`endif

  ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
`ifdef IFETCH_STATS_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return a ^ 32'hA5A5_A5A5;
  endfunction

  // Synchronous ROM, one-cycle latency.
  always @(posedge clk) if (bus.imem_req) bus.imem_rdata <= rom(bus.imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] mq [$];      // PCs buffered, oldest first
  logic [31:0] m_pc;
  int          m_infl;
  logic [31:0] m_infl_pc;
  logic [31:0] m_stall;
  logic [15:0] m_flush;

  function automatic bit m_req();
    return !reset && !bus.redirect_valid && (mq.size() + m_infl < DEPTH);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_pc = RESET_PC; m_infl = 0; m_infl_pc = '0; m_stall = '0; m_flush = '0;
    end else begin
      bit r, v;
      r = m_req();
      v = (mq.size() != 0);
      if (!v && m_stall != 32'hFFFF_FFFF) m_stall++;
      if (bus.redirect_valid && m_flush != 16'hFFFF) m_flush++;
      if (bus.redirect_valid) begin
        mq.delete();
        m_pc   = bus.redirect_pc & ~32'h3;
        m_infl = 0;
      end else begin
        if (v && bus.out_ready) void'(mq.pop_front());
        if (m_infl != 0) mq.push_back(m_infl_pc);
        m_infl = r ? 1 : 0;
        if (r) begin m_infl_pc = m_pc; m_pc = m_pc + 32'd4; end
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    bit r;
    r = m_req();
    chk("imem_req", {31'b0, bus.imem_req}, {31'b0, r});
    if (r) chk("imem_addr", bus.imem_addr, m_pc);
    chk("out_valid", {31'b0, bus.out_valid}, {31'b0, mq.size() != 0});
    if (mq.size() != 0) begin
      chk("out_pc", bus.out_pc, mq[0]);
      chk("out_instr", bus.out_instr, rom(mq[0]));
    end
`ifdef IFETCH_STATS_EN
    chk("stall_cnt", stall_cnt, m_stall);
    chk("flush_cnt", {16'b0, flush_cnt}, {16'b0, m_flush});
`endif
  end

  // Log of accepted entries as seen at the DUT output.
  logic [31:0] pops [$];
  bit          seen40 = 1'b0;
  always @(negedge clk)
    if (!reset && bus.out_valid && bus.out_ready && !bus.redirect_valid) begin
      pops.push_back(bus.out_pc);
      if (bus.out_pc == 32'h40) seen40 = 1'b1;
    end

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic sample(); @(negedge clk); #1; endtask
  task automatic run(input int n); repeat (n) begin sample(); tick(); end endtask

  task automatic chk_pop(input string name, input int idx, input logic [31:0] exp);
    if (pops.size() > idx) chk(name, pops[idx], exp);
    else chk({name, "_missing"}, pops.size(), idx + 1);
  endtask

  task automatic redirect(input logic [31:0] pc);
    bus.redirect_valid = 1'b1; bus.redirect_pc = pc;
    tick();
    bus.redirect_valid = 1'b0;
  endtask

  task automatic finish_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  initial begin
    #300000;
    errors++;
    $display("FAIL watchdog timeout");
    finish_run();
  end

  initial begin
    int nreq;
    bit found;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.out_ready      = 1'b1;

    // Reset state
    repeat (3) tick();
    sample();
    chk("rst_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_req", {31'b0, bus.imem_req}, 32'd0);
    chk("rst_pc", bus.out_pc, 32'd0);
    chk("rst_instr", bus.out_instr, 32'd0);
    tick();

    // 1: startup latency and streaming
    reset = 1'b0;
    pops.delete();
    sample();
    chk("t1_c0_req", {31'b0, bus.imem_req}, 32'd1);
    chk("t1_c0_addr", bus.imem_addr, 32'h0);
    chk("t1_c0_valid", {31'b0, bus.out_valid}, 32'd0);
    tick(); sample();
    chk("t1_c1_addr", bus.imem_addr, 32'h4);
    chk("t1_c1_valid", {31'b0, bus.out_valid}, 32'd0);
    tick(); sample();
    chk("t1_c2_valid", {31'b0, bus.out_valid}, 32'd1);
    chk("t1_c2_pc", bus.out_pc, 32'h0);
    chk("t1_c2_instr", bus.out_instr, 32'hA5A5_A5A5);
    tick();
    run(6);
    for (int i = 0; i < 6; i++) chk_pop("t1_seq", i, 32'(4 * i));

    // 2: backpressure from reset
    reset = 1'b1; tick();
    bus.out_ready = 1'b0; reset = 1'b0;
    pops.delete();
    nreq = 0;
    repeat (10) begin sample(); if (bus.imem_req) nreq++; tick(); end
    chk("t2_nreq", nreq, 32'd4);
    sample();
    chk("t2_full_req", {31'b0, bus.imem_req}, 32'd0);
    chk("t2_full_valid", {31'b0, bus.out_valid}, 32'd1);
    chk("t2_head_pc", bus.out_pc, 32'h0);
    tick();
    bus.out_ready = 1'b1;
    run(8);
    chk_pop("t2_p0", 0, 32'h0);
    chk_pop("t2_p1", 1, 32'h4);
    chk_pop("t2_p2", 2, 32'h8);
    chk_pop("t2_p3", 3, 32'hC);
    chk_pop("t2_p4", 4, 32'h10);

    // 3: redirect while full; low address bits ignored
    bus.out_ready = 1'b0;
    run(8);
    redirect(32'h102);
    sample();
    chk("t3_flushed_valid", {31'b0, bus.out_valid}, 32'd0);
    tick();
    pops.delete();
    bus.out_ready = 1'b1;
    run(6);
    chk_pop("t3_p0", 0, 32'h100);
    chk_pop("t3_p1", 1, 32'h104);

    // 4: redirect in the cycle the 0x40 word returns
    redirect(32'h30);
    seen40 = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      sample();
      if (bus.imem_req && bus.imem_addr == 32'h40) found = 1'b1;
      tick();
    end
    chk("t4_found40", {31'b0, found}, 32'd1);
    pops.delete();
    redirect(32'h200);
    run(6);
    chk("t4_no40", {31'b0, seen40}, 32'd0);
    chk_pop("t4_p0", 0, 32'h200);
    chk_pop("t4_p1", 1, 32'h204);

    // 5: asynchronous reset mid-stream
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    chk("t5_async_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("t5_async_req", {31'b0, bus.imem_req}, 32'd0);
    chk("t5_async_pc", bus.out_pc, 32'd0);
    tick(); tick();
    reset = 1'b0;
    pops.delete();
    sample();
    chk("t5_restart_addr", bus.imem_addr, RESET_PC);
    tick();
    run(5);
    chk_pop("t5_p0", 0, RESET_PC);
    chk_pop("t5_p1", 1, RESET_PC + 32'd4);

`ifdef IFETCH_STATS_EN
    // 6: statistics after 3 redirects
    reset = 1'b1; tick();
    reset = 1'b0;
    run(6);
    redirect(32'h400); run(6);
    redirect(32'h500); run(6);
    redirect(32'h600); run(6);
    sample();
    chk("t6_flush", {16'b0, flush_cnt}, 32'd3);
    chk("t6_stall", stall_cnt, 32'd8);
`endif

    finish_run();
  end
endmodule
